tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter.sv | 103 ++++++++++
 tb/tb_tx_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin two-requester arbiter feeding one byte transmitter
module tx_arbiter #(
   parameter int startTimeout = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       ack0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       ack1,
   input  logic       txdBusy,
   output logic       txdStart,
   output logic [7:0] txdData,
   output logic [1:0] grant,
   input  logic       errClear,
   output logic       error
);

   localparam logic [1:0] IDLE        = 2'd0;
   localparam logic [1:0] LOAD        = 2'd1;
   localparam logic [1:0] WAIT_ACCEPT = 2'd2;
   localparam logic [1:0] WAIT_DONE   = 2'd3;

   localparam int CW = $clog2(startTimeout + 1);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(startTimeout - 1);
   localparam logic [CW-1:0] CNT_SAT   = CW'(startTimeout);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          lastServed;
   logic          pick1;

   // Requester 1 wins when alone, or when both ask and requester 0 was served last.
   assign pick1 = req1 & (~req0 | ~lastServed);

   // Transfer sequencing: arbitrate, strobe start, wait for accept, wait for completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         lastServed <= 1'b1;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         txdStart   <= 1'b0;
         txdData    <= 8'h00;
         grant      <= 2'b00;
         error      <= 1'b0;
      end else begin
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         txdStart <= 1'b0;
         // Clear is evaluated first so a timeout set in the same cycle overrides it.
         if (state == IDLE && errClear) begin
            error <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!txdBusy && (req0 || req1)) begin
                  state   <= LOAD;
                  grant   <= pick1 ? 2'b10 : 2'b01;
                  txdData <= pick1 ? data1 : data0;
               end
            end
            LOAD: begin
               txdStart <= 1'b1;
               cnt      <= '0;
               state    <= WAIT_ACCEPT;
            end
            WAIT_ACCEPT: begin
               if (txdBusy) begin
                  ack0       <= grant[0];
                  ack1       <= grant[1];
                  lastServed <= grant[1];
                  state      <= WAIT_DONE;
               end else if (cnt >= CNT_LIMIT) begin
                  // Transmitter never answered: flag it and leave the request pending for retry.
                  error   <= 1'b1;
                  grant   <= 2'b00;
                  txdData <= 8'h00;
                  state   <= IDLE;
               end else if (cnt != CNT_SAT) begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!txdBusy) begin
                  grant   <= 2'b00;
                  txdData <= 8'h00;
                  state   <= IDLE;
               end
            end
            default: begin
               grant   <= 2'b00;
               txdData <= 8'h00;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - directed self-checking bench for tx_arbiter
module tb_tx_arbiter;

   logic       clk;
   logic       reset;
   logic       req0;
   logic [7:0] data0;
   logic       ack0;
   logic       req1;
   logic [7:0] data1;
   logic       ack1;
   logic       txdBusy;
   logic       txdStart;
   logic [7:0] txdData;
   logic [1:0] grant;
   logic       errClear;
   logic       error;

   int checks;
   int errors;

   tx_arbiter #(.startTimeout(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .req0     (req0),
      .data0    (data0),
      .ack0     (ack0),
      .req1     (req1),
      .data1    (data1),
      .ack1     (ack1),
      .txdBusy  (txdBusy),
      .txdStart (txdStart),
      .txdData  (txdData),
      .grant    (grant),
      .errClear (errClear),
      .error    (error)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_start"}, {7'd0, txdStart}, 8'h00);
      check({tag, "_data"},  txdData,          8'h00);
      check({tag, "_grant"}, {6'd0, grant},    8'h00);
      check({tag, "_ack0"},  {7'd0, ack0},     8'h00);
      check({tag, "_ack1"},  {7'd0, ack1},     8'h00);
      check({tag, "_error"}, {7'd0, error},    8'h00);
   endtask

   // One complete handshake, starting with the arbiter in IDLE and the request already posted.
   task automatic xfer(input string tag, input logic [7:0] d, input logic [1:0] g);
      step();
      check({tag, "_load_grant"}, {6'd0, grant},    {6'd0, g});
      check({tag, "_load_data"},  txdData,          d);
      check({tag, "_load_start"}, {7'd0, txdStart}, 8'h00);
      step();
      check({tag, "_start"},      {7'd0, txdStart}, 8'h01);
      txdBusy = 1'b1;
      step();
      check({tag, "_ack0"},       {7'd0, ack0},     {7'd0, g[0]});
      check({tag, "_ack1"},       {7'd0, ack1},     {7'd0, g[1]});
      check({tag, "_start_low"},  {7'd0, txdStart}, 8'h00);
      step();
      check({tag, "_ack_pulse"},  {6'd0, ack1, ack0}, 8'h00);
      check({tag, "_hold_data"},  txdData,          d);
      txdBusy = 1'b0;
      step();
      check({tag, "_done_grant"}, {6'd0, grant},    8'h00);
      check({tag, "_done_data"},  txdData,          8'h00);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b0;
      req0     = 1'b0;
      req1     = 1'b0;
      data0    = 8'h00;
      data1    = 8'h00;
      txdBusy  = 1'b0;
      errClear = 1'b0;

      // Reset state.
      step();
      step();
      check_all_zero("reset");
      reset = 1'b1;
      step();
      check_all_zero("idle_after_reset");

      // Single requester 0.
      req0  = 1'b1;
      data0 = 8'h35;
      xfer("single0", 8'h35, 2'b01);
      req0 = 1'b0;
      step();
      check("single0_no_restart", {7'd0, txdStart}, 8'h00);

      // Fresh reset, then both requesters alternate starting with 0.
      reset = 1'b0;
      step();
      reset = 1'b1;
      req0  = 1'b1;
      req1  = 1'b1;
      data0 = 8'h31;
      data1 = 8'h32;
      xfer("rr_a", 8'h31, 2'b01);
      xfer("rr_b", 8'h32, 2'b10);
      xfer("rr_c", 8'h31, 2'b01);
      xfer("rr_d", 8'h32, 2'b10);
      req0 = 1'b0;
      req1 = 1'b0;
      step();

      // Start timeout on requester 1, then retry and error clear.
      req1  = 1'b1;
      data1 = 8'h41;
      step();
      check("to_load_grant", {6'd0, grant}, 8'h02);
      step();
      check("to_start", {7'd0, txdStart}, 8'h01);
      for (int i = 0; i < 15; i++) step();
      check("to_not_yet_error", {7'd0, error}, 8'h00);
      check("to_not_yet_grant", {6'd0, grant}, 8'h02);
      check("to_not_yet_data", txdData, 8'h41);
      step();
      check("to_error", {7'd0, error}, 8'h01);
      check("to_grant_clear", {6'd0, grant}, 8'h00);
      check("to_no_ack1", {7'd0, ack1}, 8'h00);
      step();
      check("to_retry_grant", {6'd0, grant}, 8'h02);
      step();
      check("to_retry_start", {7'd0, txdStart}, 8'h01);
      txdBusy = 1'b1;
      step();
      check("to_retry_ack1", {7'd0, ack1}, 8'h01);
      req1 = 1'b0;
      step();
      txdBusy = 1'b0;
      step();
      check("to_error_sticky", {7'd0, error}, 8'h01);
      errClear = 1'b1;
      step();
      errClear = 1'b0;
      check("to_error_cleared", {7'd0, error}, 8'h00);

      // Asynchronous reset during WAIT_DONE.
      req0  = 1'b1;
      data0 = 8'h55;
      step();
      step();
      txdBusy = 1'b1;
      step();
      check("rst_ack0", {7'd0, ack0}, 8'h01);
      step();
      check("rst_wait_done_grant", {6'd0, grant}, 8'h01);
      #1 reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      step();
      reset = 1'b1;
      step();
      step();
      check("rst_busy_hold_start", {7'd0, txdStart}, 8'h00);
      check("rst_busy_hold_grant", {6'd0, grant}, 8'h00);
      txdBusy = 1'b0;
      xfer("rst_resume", 8'h55, 2'b01);
      req0 = 1'b0;
      step();

      // External busy blocks a start.
      txdBusy = 1'b1;
      req0    = 1'b1;
      data0   = 8'h66;
      step();
      step();
      step();
      check("ext_busy_start", {7'd0, txdStart}, 8'h00);
      check("ext_busy_grant", {6'd0, grant}, 8'h00);
      txdBusy = 1'b0;
      xfer("ext_busy_release", 8'h66, 2'b01);
      req0 = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
